dmem_responder: RTL and testbench

- Memory-side responder for the CPU's data-load/store request channel.
- Accepts one word-aligned load or store over a valid/ready request handshake.
- Services the request from an internal word array after a fixed, programmable number of wait states.
- Returns read data and an error flag over a valid/ready response handshake. Used as the data memory behind the datapath for multi-cycle and stall testing.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU data port and the data memory.
// The CPU side drives requests and accepts responses.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed wait states,
// registered valid/ready handshakes on both request and response.
module dmem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             reset_n,
    dmem_responder_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] idx;
    logic                 addr_err;
    logic                 exec;
    logic                 mem_we;

    assign idx      = addr_q[ADDR_BITS+1:2];
    assign addr_err = (|addr_q[1:0]) | (|addr_q[31:ADDR_BITS+2]);
    // The access happens on the edge that leaves WAIT for RESP.
    assign exec     = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we   = exec && we_q && !addr_err;

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Next-state and registered-output computation for the handshake FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    be_d        = bus.req_be;
                    req_ready_d = 1'b0;
                    cnt_d       = 4'(WAIT_CYCLES);
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = addr_err;
                    resp_rdata_d = (addr_err || we_q) ? 32'd0 : mem[idx];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, latched request and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Byte-masked store into the word array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps plus random traffic on a
// WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n [2];

    logic        rv [2];
    logic        rw [2];
    logic        rr [2];
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    logic [3:0]  rb [2];

    logic        ordy [2];
    logic        oval [2];
    logic [31:0] odat [2];
    logic        oerr [2];

    logic [31:0] mdl [2][1024];

    int tests = 0;
    int fails = 0;

    dmem_responder_if b0 ();
    dmem_responder_if b1 ();

    assign b0.req_valid  = rv[0];
    assign b0.req_we     = rw[0];
    assign b0.req_addr   = ra[0];
    assign b0.req_wdata  = rd[0];
    assign b0.req_be     = rb[0];
    assign b0.resp_ready = rr[0];
    assign b1.req_valid  = rv[1];
    assign b1.req_we     = rw[1];
    assign b1.req_addr   = ra[1];
    assign b1.req_wdata  = rd[1];
    assign b1.req_be     = rb[1];
    assign b1.resp_ready = rr[1];

    assign ordy[0] = b0.req_ready;
    assign oval[0] = b0.resp_valid;
    assign odat[0] = b0.resp_rdata;
    assign oerr[0] = b0.resp_err;
    assign ordy[1] = b1.req_ready;
    assign oval[1] = b1.resp_valid;
    assign odat[1] = b1.resp_rdata;
    assign oerr[1] = b1.resp_err;

    dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut0 (
        .clk     (clk),
        .reset_n (rst_n[0]),
        .bus     (b0)
    );

    dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut1 (
        .clk     (clk),
        .reset_n (rst_n[1]),
        .bus     (b1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, checked against the word-array model.
    task automatic txn(input int s, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int hold);
        logic [31:0] exp_d;
        logic        exp_e;
        int          lat;
        int          w;
        w     = (s == 0) ? 2 : 0;
        exp_e = (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
        exp_d = (exp_e || we) ? 32'd0 : mdl[s][int'(a[11:2])];
        lat = 0;
        while (!ordy[s] && lat < 20) begin
            tick();
            lat++;
        end
        chk("req_ready_before_accept", 32'(ordy[s]), 32'd1);
        rv[s] = 1'b1;
        rw[s] = we;
        ra[s] = a;
        rd[s] = wd;
        rb[s] = be;
        rr[s] = 1'b1;
        tick();
        rv[s] = 1'b0;
        rw[s] = 1'($urandom);
        ra[s] = $urandom;
        rd[s] = $urandom;
        rb[s] = 4'($urandom);
        lat = 0;
        while (!oval[s] && lat < 40) begin
            tick();
            lat++;
        end
        chk("resp_latency", lat, w + 1);
        chk("resp_rdata", odat[s], exp_d);
        chk("resp_err", 32'(oerr[s]), 32'(exp_e));
        if (!exp_e && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl[s][int'(a[11:2])][8*b +: 8] = wd[8*b +: 8];
            end
        end
        if (hold > 0) begin
            rr[s] = 1'b0;
            rv[s] = 1'b1;
            ra[s] = 32'h0000_0020;
            rw[s] = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold_valid", 32'(oval[s]), 32'd1);
                chk("hold_rdata", odat[s], exp_d);
                chk("hold_err", 32'(oerr[s]), 32'(exp_e));
                chk("hold_req_ready", 32'(ordy[s]), 32'd0);
            end
            rr[s] = 1'b1;
            tick();
            rv[s] = 1'b0;
            chk("release_valid", 32'(oval[s]), 32'd0);
            chk("release_req_ready", 32'(ordy[s]), 32'd1);
            tick();
            chk("no_stray_accept", 32'(ordy[s]), 32'd1);
        end else begin
            tick();
            chk("handshake_valid", 32'(oval[s]), 32'd0);
            chk("handshake_req_ready", 32'(ordy[s]), 32'd1);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        logic [31:0] base;
        k    = $urandom_range(0, 9);
        base = 32'($urandom_range(0, 15)) << 2;
        if (k <= 6) return base;
        if (k == 7) return base | 32'($urandom_range(1, 3));
        if (k == 8) return ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        return base | 32'h8000_0000;
    endfunction

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0;
            rv[s] = 1'b0;
            rw[s] = 1'b0;
            rr[s] = 1'b1;
            ra[s] = 32'd0;
            rd[s] = 32'd0;
            rb[s] = 4'd0;
        end
        #23;
        chk("reset_req_ready", 32'(ordy[0]), 32'd0);
        chk("reset_resp_valid", 32'(oval[0]), 32'd0);
        chk("reset_resp_rdata", odat[0], 32'd0);
        chk("reset_resp_err", 32'(oerr[0]), 32'd0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        chk("ready_low_before_edge", 32'(ordy[0]), 32'd0);
        tick();
        chk("ready_after_reset", 32'(ordy[0]), 32'd1);
        chk("ready_after_reset_w0", 32'(ordy[1]), 32'd1);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                txn(s, 1'b1, 32'(i) << 2, $urandom, 4'hF, 0);
            end
        end

        txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        txn(0, 1'b0, 32'h0000_0010, 32'd0, 4'hF, 0);
        chk("directed_store_model", mdl[0][4], 32'hDEAD_BEEF);
        txn(0, 1'b1, 32'h0000_0010, 32'h0000_AA00, 4'b0010, 0);
        txn(0, 1'b0, 32'h0000_0010, 32'd0, 4'hF, 0);
        txn(0, 1'b0, 32'h0000_0012, 32'd0, 4'hF, 0);
        txn(0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0);
        txn(0, 1'b0, 32'h0000_0000, 32'd0, 4'hF, 0);
        txn(0, 1'b1, 32'h0000_0008, 32'h5555_5555, 4'b0000, 0);
        txn(0, 1'b0, 32'h0000_0008, 32'd0, 4'hF, 0);
        txn(0, 1'b0, 32'h0000_0010, 32'd0, 4'hF, 5);

        while (!ordy[0]) tick();
        rv[0] = 1'b1;
        rw[0] = 1'b1;
        ra[0] = 32'h0000_0010;
        rd[0] = 32'h1234_5678;
        rb[0] = 4'hF;
        tick();
        rv[0] = 1'b0;
        tick();
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("midop_reset_req_ready", 32'(ordy[0]), 32'd0);
        chk("midop_reset_resp_valid", 32'(oval[0]), 32'd0);
        chk("midop_reset_resp_rdata", odat[0], 32'd0);
        chk("midop_reset_resp_err", 32'(oerr[0]), 32'd0);
        tick();
        tick();
        #2;
        rst_n[0] = 1'b1;
        tick();
        chk("midop_ready_after_release", 32'(ordy[0]), 32'd1);
        txn(0, 1'b0, 32'h0000_0010, 32'd0, 4'hF, 0);

        for (int n = 0; n < 40; n++) begin
            txn(0, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
                int'($urandom_range(0, 3)));
        end

        for (int n = 0; n < 4; n++) begin
            txn(1, 1'b0, 32'(n) << 2, 32'd0, 4'hF, 0);
        end
        for (int n = 0; n < 30; n++) begin
            txn(1, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
                int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
